uart_tx_gen: RTL and testbench
==============================

UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLK_DIV, default 16, txclk cycles per bit period, legal range 1..65535.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-004 SHALL have port txclk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-007 SHALL have port tx_ready  output  1  block can accept a frame this cycle.
REQ-008 SHALL have port tx_data  input  DATA_W  payload, sent LSB first.
REQ-009 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even; captured at accept.
REQ-010 SHALL have port tx_out  output  1  serial line, idle high.
REQ-011 SHALL have port tx_busy  output  1  frame in progress.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL transition IDLE->START, DATA->PARITY (or STOP), PARITY->STOP, STOP->IDLE/START, with each non-IDLE bit lasting exactly CLK_DIV cycles via the baud counter.
REQ-015 SHALL drive tx_ready=1 only in IDLE or in the final cycle of the last stop bit; accept = tx_valid & tx_ready.
REQ-016 SHALL capture tx_data and parity_odd into internal registers on accept; later input changes SHALL NOT affect the frame in flight.
REQ-017 SHALL drive tx_out from a register, low from the cycle after accept (1-cycle latency).
REQ-018 SHALL send DATA_W data bits LSB first, using a bit counter of width clog2(DATA_W+1).
REQ-019 SHALL compute the parity bit as XOR of the captured data XOR parity_odd, so the total ones count is odd when parity_odd=1 and even when 0.
REQ-020 SHALL hold tx_out=1 for STOP_BITS bit periods in STOP.
REQ-021 SHALL pulse tx_done for one cycle in the last cycle of the final stop bit.
REQ-022 SHALL, on accept in that same cycle, go directly to START with no idle gap (back-to-back); otherwise return to IDLE.
REQ-023 SHALL set tx_busy=1 in every state except IDLE.
REQ-024 SHALL make the frame length (1 + DATA_W + P + STOP_BITS) x CLK_DIV cycles, where P=1 with parity compiled in, else 0.
REQ-025 SHALL work with CLK_DIV=1 (one cycle per bit) with no counter underflow.

Reset
REQ-026 SHALL, on reset, set state=IDLE, tx_out=1, tx_ready=0, tx_busy=0, tx_done=0, and clear counters and capture registers.
REQ-027 SHALL assert tx_ready=1 the cycle after reset deasserts.
REQ-028 SHALL, on reset mid-frame, abort the frame: tx_out=1 at the next edge, no tx_done, and no resumption.

Configuration
REQ-029 SHALL, with UART_TX_PARITY_EN defined, include the PARITY state and the parity bit.
REQ-030 SHALL, without UART_TX_PARITY_EN, omit the PARITY state, ignore parity_odd (port kept), and go DATA->STOP.

Structure
REQ-031 SHALL place the FSM state enum, the legal-range constants for DATA_W and STOP_BITS, and the parity mode constants in shared package uart_pkg.
REQ-032 SHALL implement the baud counter as sub-module uart_baud_gen (CLK_DIV parameter; restart input; one-cycle bit_tick output).
REQ-033 SHALL reject an illegal parameter with an elaboration-time error.

Verification
REQ-034 SHALL cover: DATA_W=8, CLK_DIV=4, parity on, even, tx_data=8'hA5 -> line 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles; tx_done 44 cycles after accept.
REQ-035 SHALL cover: odd parity, tx_data=8'h00 -> parity bit 1; even parity, 8'h00 -> parity bit 0.
REQ-036 SHALL cover: tx_valid held high for 3 frames -> start bits directly follow stop bits with no gap; 3 tx_done pulses spaced 44 cycles apart.
REQ-037 SHALL cover: reset asserted during data bit 3 -> tx_out=1 next cycle, no tx_done, tx_ready=1 the cycle after reset release.
REQ-038 SHALL cover: UART_TX_PARITY_EN undefined, STOP_BITS=2, CLK_DIV=1, tx_data=8'h3C -> 11-bit frame 0,0,0,1,1,1,1,0,0,1,1; tx_done at cycle 11.
REQ-039 SHALL cover: DATA_W=9, tx_data=9'h1FF, odd parity -> nine 1 data bits, parity bit 0, tx_data changed mid-frame has no effect.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DATA_W_MIN    = 5;
    localparam int DATA_W_MAX    = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;
    localparam int CLK_DIV_MIN   = 1;
    localparam int CLK_DIV_MAX   = 65535;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic bit in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last txclk cycle of every CLK_DIV-cycle bit.
module uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic txclk,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);

    // A divide-by-one counter still needs one bit of storage; it simply never leaves zero.
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge txclk) begin
        if (reset || restart || bit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bit_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_gen.sv
// UART frame transmitter: start, DATA_W bits LSB first, optional parity, STOP_BITS stops.
// Define UART_TX_PARITY_EN to include the parity bit; otherwise parity_odd is ignored.
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              txclk,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              parity_odd,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    if (!in_range(DATA_W, DATA_W_MIN, DATA_W_MAX)) begin : g_bad_data_w
        $error("uart_tx_gen: DATA_W=%0d outside %0d..%0d", DATA_W, DATA_W_MIN, DATA_W_MAX);
    end
    if (!in_range(CLK_DIV, CLK_DIV_MIN, CLK_DIV_MAX)) begin : g_bad_clk_div
        $error("uart_tx_gen: CLK_DIV=%0d outside %0d..%0d", CLK_DIV, CLK_DIV_MIN, CLK_DIV_MAX);
    end
    if (!in_range(STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX)) begin : g_bad_stop_bits
        $error("uart_tx_gen: STOP_BITS=%0d outside %0d..%0d", STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX);
    end

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t         state_q;
    tx_state_t         state_d;
    logic [DATA_W-1:0] shift_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              stop_cnt_q;
    logic              tx_out_q;
    logic              bit_tick;
    logic              accept;
    logic              last_data;
    logic              last_stop;

`ifdef UART_TX_PARITY_EN
    logic              par_q;
`else
    logic              unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .txclk    (txclk),
        .reset    (reset),
        .restart  (accept || (state_q == IDLE)),
        .bit_tick (bit_tick)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        last_data = (bit_cnt_q == LAST_BIT);
        last_stop = (state_q == STOP) && bit_tick && (stop_cnt_q == LAST_STOP);
        tx_ready  = !reset && ((state_q == IDLE) || last_stop);
        tx_done   = !reset && last_stop;
        accept    = tx_valid && tx_ready;
        state_d   = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = START;
            START:  if (bit_tick) state_d = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_tick && last_data) state_d = PARITY;
            PARITY: if (bit_tick) state_d = STOP;
`else
            DATA:   if (bit_tick && last_data) state_d = STOP;
`endif
            STOP:   if (last_stop) state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // shift_q[0] is always the data bit currently on the line while in DATA.
    always_ff @(posedge txclk) begin
        if (reset) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_out_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q      <= PARITY_EVEN;
`endif
        end else if (accept) begin
            shift_q    <= tx_data;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_out_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            // Seeding with 1 for odd mode makes the running XOR the finished parity bit.
            par_q      <= (parity_odd == PARITY_ODD);
`endif
        end else if (bit_tick) begin
            case (state_q)
                START: tx_out_q <= shift_q[0];
                DATA: begin
                    shift_q   <= shift_q >> 1;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_q     <= par_q ^ shift_q[0];
                    tx_out_q  <= last_data ? (par_q ^ shift_q[0]) : shift_q[1];
`else
                    tx_out_q  <= last_data ? 1'b1 : shift_q[1];
`endif
                end
                PARITY: tx_out_q <= 1'b1;
                STOP: begin
                    tx_out_q <= 1'b1;
                    if (!last_stop) stop_cnt_q <= stop_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_gen.sv
// Scoreboard bench for uart_tx_gen: three configurations, expected line/done per cycle queued at accept.
module tb_uart_tx_gen;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    localparam int DW_A = 8, DIV_A = 4, ST_A = 1;
    localparam int DW_B = 8, DIV_B = 1, ST_B = 2;
    localparam int DW_C = 9, DIV_C = 3, ST_C = 1;

    typedef struct packed {
        logic [1:0] dut;
        logic       line;
        logic       done;
    } exp_t;

    logic       txclk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] valid = '0;
    logic [2:0] odd   = '0;
    logic [2:0] ready;
    logic [2:0] line;
    logic [2:0] busy;
    logic [2:0] done;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic [8:0] data_c = '0;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    always #5 txclk = ~txclk;

    uart_tx_gen #(.DATA_W(DW_A), .CLK_DIV(DIV_A), .STOP_BITS(ST_A)) dut_a (
        .txclk(txclk), .reset(reset), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .tx_data(data_a), .parity_odd(odd[0]), .tx_out(line[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );
    uart_tx_gen #(.DATA_W(DW_B), .CLK_DIV(DIV_B), .STOP_BITS(ST_B)) dut_b (
        .txclk(txclk), .reset(reset), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .tx_data(data_b), .parity_odd(odd[1]), .tx_out(line[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );
    uart_tx_gen #(.DATA_W(DW_C), .CLK_DIV(DIV_C), .STOP_BITS(ST_C)) dut_c (
        .txclk(txclk), .reset(reset), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .tx_data(data_c), .parity_odd(odd[2]), .tx_out(line[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int dw_of(input int d);
        return (d == 0) ? DW_A : (d == 1) ? DW_B : DW_C;
    endfunction
    function automatic int div_of(input int d);
        return (d == 0) ? DIV_A : (d == 1) ? DIV_B : DIV_C;
    endfunction
    function automatic int st_of(input int d);
        return (d == 0) ? ST_A : (d == 1) ? ST_B : ST_C;
    endfunction

    // Frame model: bit sequence from the line format, stretched to one entry per txclk cycle.
    function automatic void push_frame(input int d, input logic [8:0] data, input logic po);
        logic bq[$];
        logic p;
        bq.push_back(1'b0);
        p = po;
        for (int i = 0; i < dw_of(d); i++) begin
            bq.push_back(data[i]);
            p = p ^ data[i];
        end
        if (PAR == 1) bq.push_back(p);
        for (int s = 0; s < st_of(d); s++) bq.push_back(1'b1);
        for (int k = 0; k < bq.size(); k++) begin
            for (int c = 0; c < div_of(d); c++) begin
                exp_q.push_back('{dut: 2'(d), line: bq[k],
                                  done: (k == bq.size() - 1) && (c == div_of(d) - 1)});
            end
        end
    endfunction

    // Raises tx_valid and returns #1 after the accepting edge; tx_valid is left high.
    task automatic send(input int d, input logic [8:0] data, input logic po);
        bit rdy;
        bit ok;
        ok = 1'b0;
        case (d)
            0:       data_a = data[7:0];
            1:       data_b = data[7:0];
            default: data_c = data;
        endcase
        odd[d]   = po;
        valid[d] = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge txclk);
            rdy = ready[d];
            @(posedge txclk);
            ok = rdy;
        end
        check("accept", 32'(ok), 32'd1);
        #1;
        if (ok) push_frame(d, data, po);
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) begin
            @(posedge txclk);
            #1;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge txclk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("line",  32'(line[e.dut]),  32'(e.line));
                check("done",  32'(done[e.dut]),  32'(e.done));
                check("busy",  32'(busy[e.dut]),  32'd1);
                check("ready", 32'(ready[e.dut]), 32'(e.done));
            end else if (!reset) begin
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_done", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge txclk);
        @(negedge txclk);
        check("rst_line",  32'(line),  32'b111);
        check("rst_busy",  32'(busy),  32'b000);
        check("rst_ready", 32'(ready), 32'b000);
        check("rst_done",  32'(done),  32'b000);
        @(posedge txclk);
        #1 reset = 1'b0;
        @(posedge txclk);
        @(negedge txclk);
        check("rel_ready", 32'(ready), 32'b111);
        @(posedge txclk);
        #1 mon_en = 1'b1;

        // 0xA5, even parity, 4 cycles per bit
        send(0, 9'h0A5, 1'b0);
        valid[0] = 1'b0;
        wait_idle(200);

        // all-zero payload in both parity modes
        send(0, 9'h000, 1'b1);
        valid[0] = 1'b0;
        wait_idle(200);
        send(0, 9'h000, 1'b0);
        valid[0] = 1'b0;
        wait_idle(200);

        // back-to-back frames with tx_valid held high
        send(0, 9'h05A, 1'b1);
        send(0, 9'h0C3, 1'b0);
        send(0, 9'h00F, 1'b1);
        valid[0] = 1'b0;
        wait_idle(400);

        // reset in the middle of data bit 3 (cycles 17..20 after accept)
        send(0, 9'h0F0, 1'b0);
        valid[0] = 1'b0;
        repeat (17) @(posedge txclk);
        #1 reset = 1'b1;
        @(posedge txclk);
        #1 exp_q.delete();
        @(negedge txclk);
        check("abort_line", 32'(line[0]), 32'd1);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        @(posedge txclk);
        #1 reset = 1'b0;
        @(posedge txclk);
        @(negedge txclk);
        check("abort_ready", 32'(ready[0]), 32'd1);
        repeat (8) @(posedge txclk);
        @(negedge txclk);
        check("no_resume_line", 32'(line[0]), 32'd1);
        check("no_resume_busy", 32'(busy[0]), 32'd0);
        @(posedge txclk);
        #1;

        // one cycle per bit, two stop bits
        send(1, 9'h03C, 1'b0);
        valid[1] = 1'b0;
        wait_idle(100);

        // nine-bit payload; inputs changed right after accept
        send(2, 9'h1FF, 1'b1);
        valid[2] = 1'b0;
        data_c   = 9'h000;
        odd[2]   = 1'b0;
        wait_idle(200);

        repeat (4) @(posedge txclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
